// File: rtl/tag_lookup_ctrl_pkg.sv
// Shared types and helpers for the tag lookup controller.
// Holds the FSM state encoding and the saturating counter increment.
package tag_lookup_ctrl_pkg;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      RD   = 2'd1,
      RSP  = 2'd2
   } state_t;

   localparam int unsigned SAT_MAX_W = 64;

   // Increment val, holding at the all-ones value of a w-bit counter.
   function automatic logic [SAT_MAX_W-1:0] sat_inc(input logic [SAT_MAX_W-1:0] val,
                                                    input int unsigned          w);
      logic [SAT_MAX_W-1:0] top;
      top = (SAT_MAX_W'(1) << w) - SAT_MAX_W'(1);
      return (val >= top) ? val : val + SAT_MAX_W'(1);
   endfunction

endpackage

// File: rtl/tag_lookup_ctrl.sv
// Arbiter and lookup sequencer for a single-cycle-invalidate tag memory.
// Priority invalidate > fill > lookup; lookups run IDLE -> RD -> RSP.
module tag_lookup_ctrl
   import tag_lookup_ctrl_pkg::*;
#(
   parameter int unsigned DEPTH = 32,
   parameter int unsigned WIDTH = 32,
   parameter int unsigned CNT_W = 16
) (
   input  logic                     i_clk,
   input  logic                     i_reset,
   input  logic                     i_inv_req,
   output logic                     o_inv_ack,
   input  logic                     i_fill_valid,
   output logic                     o_fill_ready,
   input  logic [$clog2(DEPTH)-1:0] i_fill_idx,
   input  logic [WIDTH-1:0]         i_fill_tag,
   input  logic                     i_lkp_valid,
   output logic                     o_lkp_ready,
   input  logic [$clog2(DEPTH)-1:0] i_lkp_idx,
   input  logic [WIDTH-1:0]         i_lkp_tag,
   output logic                     o_rsp_valid,
   input  logic                     i_rsp_ready,
   output logic                     o_rsp_hit,
   output logic [WIDTH-1:0]         o_rsp_tag,
   output logic                     o_mem_wen,
   output logic [$clog2(DEPTH)-1:0] o_mem_waddr,
   output logic [WIDTH-1:0]         o_mem_wdata,
   output logic                     o_mem_ren,
   output logic [$clog2(DEPTH)-1:0] o_mem_raddr,
   output logic                     o_mem_inv,
   input  logic [WIDTH-1:0]         i_mem_rdata,
   input  logic                     i_mem_rdav,
   output logic [CNT_W-1:0]         o_hit_cnt,
   output logic [CNT_W-1:0]         o_miss_cnt
);

   localparam int unsigned IDX_W = $clog2(DEPTH);

   state_t           state_q, state_d;
   logic [WIDTH-1:0] tag_q, tag_d;
   logic             inv_ack_d, rsp_valid_d, rsp_hit_d, hit;
   logic [WIDTH-1:0] rsp_tag_d;
   logic [CNT_W-1:0] hit_cnt_d, miss_cnt_d;

   always_ff @(posedge i_clk or posedge i_reset) begin
      if (i_reset) begin
         state_q     <= IDLE;
         tag_q       <= '0;
         o_inv_ack   <= 1'b0;
         o_rsp_valid <= 1'b0;
         o_rsp_hit   <= 1'b0;
         o_rsp_tag   <= '0;
         o_hit_cnt   <= '0;
         o_miss_cnt  <= '0;
      end else begin
         state_q     <= state_d;
         tag_q       <= tag_d;
         o_inv_ack   <= inv_ack_d;
         o_rsp_valid <= rsp_valid_d;
         o_rsp_hit   <= rsp_hit_d;
         o_rsp_tag   <= rsp_tag_d;
         o_hit_cnt   <= hit_cnt_d;
         o_miss_cnt  <= miss_cnt_d;
      end
   end

   // Next state, next registered values and the combinational memory/handshake side.
   always_comb begin
      state_d      = state_q;
      tag_d        = tag_q;
      inv_ack_d    = 1'b0;
      rsp_valid_d  = o_rsp_valid;
      rsp_hit_d    = o_rsp_hit;
      rsp_tag_d    = o_rsp_tag;
      hit_cnt_d    = o_hit_cnt;
      miss_cnt_d   = o_miss_cnt;
      hit          = i_mem_rdav && (i_mem_rdata == tag_q);
      o_fill_ready = 1'b0;
      o_lkp_ready  = 1'b0;
      o_mem_wen    = 1'b0;
      o_mem_waddr  = '0;
      o_mem_wdata  = '0;
      o_mem_ren    = 1'b0;
      o_mem_raddr  = '0;
      o_mem_inv    = 1'b0;

      case (state_q)
         IDLE: begin
            o_fill_ready = !i_inv_req;
            o_lkp_ready  = !i_inv_req && !i_fill_valid;
            if (i_inv_req) begin
               o_mem_inv = 1'b1;
               inv_ack_d = 1'b1;
            end else if (i_fill_valid) begin
               o_mem_wen   = 1'b1;
               o_mem_waddr = i_fill_idx;
               o_mem_wdata = i_fill_tag;
            end else if (i_lkp_valid) begin
               o_mem_ren   = 1'b1;
               o_mem_raddr = i_lkp_idx;
               tag_d       = i_lkp_tag;
               state_d     = RD;
            end
         end
         RD: begin
            rsp_valid_d = 1'b1;
            rsp_hit_d   = hit;
            rsp_tag_d   = i_mem_rdata;
            if (hit) hit_cnt_d  = CNT_W'(sat_inc(SAT_MAX_W'(o_hit_cnt), CNT_W));
            else     miss_cnt_d = CNT_W'(sat_inc(SAT_MAX_W'(o_miss_cnt), CNT_W));
            state_d = RSP;
         end
         RSP: begin
            if (i_rsp_ready) begin
               rsp_valid_d = 1'b0;
               state_d     = IDLE;
            end
         end
         default: state_d = IDLE;
      endcase
   end

   logic unused_idx;
   assign unused_idx = ^IDX_W'(0);

endmodule

// File: tb/tb_tag_lookup_ctrl.sv
// Directed bench for tag_lookup_ctrl with a behavioural tag memory model.
module tb_tag_lookup_ctrl;

   localparam int unsigned DEPTH   = 32;
   localparam int unsigned WIDTH   = 32;
   localparam int unsigned CNT_W   = 4;
   localparam int unsigned IDX_W   = $clog2(DEPTH);
   localparam int unsigned CNT_MAX = (1 << CNT_W) - 1;

   logic             clk = 1'b0;
   logic             rst;
   logic             inv_req, inv_ack;
   logic             fill_valid, fill_ready;
   logic [IDX_W-1:0] fill_idx;
   logic [WIDTH-1:0] fill_tag;
   logic             lkp_valid, lkp_ready;
   logic [IDX_W-1:0] lkp_idx;
   logic [WIDTH-1:0] lkp_tag;
   logic             rsp_valid, rsp_ready, rsp_hit;
   logic [WIDTH-1:0] rsp_tag;
   logic             mem_wen, mem_ren, mem_inv;
   logic [IDX_W-1:0] mem_waddr, mem_raddr;
   logic [WIDTH-1:0] mem_wdata, mem_rdata;
   logic             mem_rdav;
   logic [CNT_W-1:0] hit_cnt, miss_cnt;

   int n_pass = 0;
   int n_total = 0;
   int exp_hits = 0;
   int exp_miss = 0;

   always #5 clk = ~clk;

   tag_lookup_ctrl #(.DEPTH(DEPTH), .WIDTH(WIDTH), .CNT_W(CNT_W)) dut (
      .i_clk(clk), .i_reset(rst),
      .i_inv_req(inv_req), .o_inv_ack(inv_ack),
      .i_fill_valid(fill_valid), .o_fill_ready(fill_ready),
      .i_fill_idx(fill_idx), .i_fill_tag(fill_tag),
      .i_lkp_valid(lkp_valid), .o_lkp_ready(lkp_ready),
      .i_lkp_idx(lkp_idx), .i_lkp_tag(lkp_tag),
      .o_rsp_valid(rsp_valid), .i_rsp_ready(rsp_ready),
      .o_rsp_hit(rsp_hit), .o_rsp_tag(rsp_tag),
      .o_mem_wen(mem_wen), .o_mem_waddr(mem_waddr), .o_mem_wdata(mem_wdata),
      .o_mem_ren(mem_ren), .o_mem_raddr(mem_raddr), .o_mem_inv(mem_inv),
      .i_mem_rdata(mem_rdata), .i_mem_rdav(mem_rdav),
      .o_hit_cnt(hit_cnt), .o_miss_cnt(miss_cnt)
   );

   // Tag memory model: registered read, single-cycle invalidate-all.
   logic [WIDTH-1:0] mem   [DEPTH];
   logic             vbit  [DEPTH];
   initial begin
      for (int i = 0; i < DEPTH; i++) begin
         mem[i]  = '0;
         vbit[i] = 1'b0;
      end
      mem_rdata = '0;
      mem_rdav  = 1'b0;
   end
   always @(posedge clk) begin
      if (mem_inv) begin
         for (int i = 0; i < DEPTH; i++) vbit[i] <= 1'b0;
      end else if (mem_wen) begin
         mem[mem_waddr]  <= mem_wdata;
         vbit[mem_waddr] <= 1'b1;
      end
      if (mem_ren) begin
         mem_rdata <= mem[mem_raddr];
         mem_rdav  <= vbit[mem_raddr];
      end
   end

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_total++;
      if (act !== exp) $display("FAIL %s: got 0x%0h, want 0x%0h", name, act, exp);
      else n_pass++;
   endtask

   task automatic count_expect(input logic h);
      if (h) begin if (exp_hits < CNT_MAX) exp_hits++; end
      else   begin if (exp_miss < CNT_MAX) exp_miss++; end
   endtask

   task automatic do_fill(input logic [IDX_W-1:0] idx, input logic [WIDTH-1:0] tag);
      @(posedge clk); #1;
      fill_valid = 1'b1; fill_idx = idx; fill_tag = tag;
      @(negedge clk);
      check("fill_ready", 64'(fill_ready), 64'(1));
      check("fill_wen", 64'(mem_wen), 64'(1));
      @(posedge clk); #1;
      fill_valid = 1'b0;
   endtask

   task automatic do_lookup(input logic [IDX_W-1:0] idx, input logic [WIDTH-1:0] tag,
                            input logic ack_rsp, output logic hit, output logic [WIDTH-1:0] rtag,
                            output int lat);
      int n;
      @(posedge clk); #1;
      lkp_valid = 1'b1; lkp_idx = idx; lkp_tag = tag;
      @(negedge clk);
      n = 0;
      while (!lkp_ready && n < 20) begin @(negedge clk); n++; end
      if (n == 20) check("lkp_accept_timeout", 64'(0), 64'(1));
      check("ren_accept", 64'(mem_ren), 64'(1));
      check("raddr_accept", 64'(mem_raddr), 64'(idx));
      @(posedge clk); #1;
      lkp_valid = 1'b0;
      lat = 0;
      do begin
         @(negedge clk); lat++;
         if (lat == 1) check("ren_rd_low", 64'(mem_ren), 64'(0));
      end while (!rsp_valid && lat < 20);
      hit  = rsp_hit;
      rtag = rsp_tag;
      if (ack_rsp) begin
         rsp_ready = 1'b1;
         @(posedge clk); #1;
         rsp_ready = 1'b0;
      end
   endtask

   typedef struct {
      logic             do_fill;
      logic [IDX_W-1:0] fidx;
      logic [WIDTH-1:0] ftag;
      logic [IDX_W-1:0] lidx;
      logic [WIDTH-1:0] ltag;
      logic             exp_hit;
      logic [WIDTH-1:0] exp_tag;
   } vec_t;

   vec_t vecs[8];

   initial begin
      logic             h;
      logic [WIDTH-1:0] t, held_tag;
      logic             held_hit;
      int               lat;

      vecs[0] = '{1'b0, 5'd0,  32'h0,         5'd5,  32'h0000ABCD, 1'b0, 32'h0};
      vecs[1] = '{1'b1, 5'd5,  32'h0000ABCD,  5'd5,  32'h0000ABCD, 1'b1, 32'h0000ABCD};
      vecs[2] = '{1'b0, 5'd0,  32'h0,         5'd5,  32'h0000ABCE, 1'b0, 32'h0000ABCD};
      vecs[3] = '{1'b1, 5'd7,  32'h12345678,  5'd7,  32'h12345678, 1'b1, 32'h12345678};
      vecs[4] = '{1'b0, 5'd0,  32'h0,         5'd6,  32'h00000000, 1'b0, 32'h0};
      vecs[5] = '{1'b1, 5'd31, 32'hFFFFFFFF,  5'd31, 32'hFFFFFFFF, 1'b1, 32'hFFFFFFFF};
      vecs[6] = '{1'b1, 5'd0,  32'hDEADBEEF,  5'd0,  32'hDEADBEEF, 1'b1, 32'hDEADBEEF};
      vecs[7] = '{1'b0, 5'd0,  32'h0,         5'd31, 32'hFFFFFFFE, 1'b0, 32'hFFFFFFFF};

      rst = 1'b1;
      inv_req = 1'b0; fill_valid = 1'b0; lkp_valid = 1'b0; rsp_ready = 1'b0;
      fill_idx = '0; fill_tag = '0; lkp_idx = '0; lkp_tag = '0;
      #3;
      check("rst_inv_ack", 64'(inv_ack), 64'(0));
      check("rst_rsp_valid", 64'(rsp_valid), 64'(0));
      check("rst_rsp_hit", 64'(rsp_hit), 64'(0));
      check("rst_rsp_tag", 64'(rsp_tag), 64'(0));
      check("rst_hit_cnt", 64'(hit_cnt), 64'(0));
      check("rst_miss_cnt", 64'(miss_cnt), 64'(0));
      @(negedge clk); @(negedge clk);
      rst = 1'b0;

      // Table-driven fill/lookup pairs.
      for (int i = 0; i < 8; i++) begin
         if (vecs[i].do_fill) do_fill(vecs[i].fidx, vecs[i].ftag);
         do_lookup(vecs[i].lidx, vecs[i].ltag, 1'b1, h, t, lat);
         count_expect(vecs[i].exp_hit);
         check($sformatf("v%0d_latency", i), 64'(lat), 64'(2));
         check($sformatf("v%0d_hit", i), 64'(h), 64'(vecs[i].exp_hit));
         check($sformatf("v%0d_tag", i), 64'(t), 64'(vecs[i].exp_tag));
         check($sformatf("v%0d_hit_cnt", i), 64'(hit_cnt), 64'(exp_hits));
         check($sformatf("v%0d_miss_cnt", i), 64'(miss_cnt), 64'(exp_miss));
      end

      // Invalidate, fill and lookup all requested in one IDLE cycle.
      @(posedge clk); #1;
      inv_req = 1'b1;
      fill_valid = 1'b1; fill_idx = 5'd9; fill_tag = 32'h99;
      lkp_valid = 1'b1;  lkp_idx = 5'd5;  lkp_tag = 32'h0000ABCD;
      @(negedge clk);
      check("arb_inv", 64'(mem_inv), 64'(1));
      check("arb_fill_rdy", 64'(fill_ready), 64'(0));
      check("arb_lkp_rdy", 64'(lkp_ready), 64'(0));
      check("arb_wen", 64'(mem_wen), 64'(0));
      check("arb_ren", 64'(mem_ren), 64'(0));
      check("arb_ack_early", 64'(inv_ack), 64'(0));
      @(posedge clk); #1;
      inv_req = 1'b0;
      @(negedge clk);
      check("arb_ack", 64'(inv_ack), 64'(1));
      check("arb_fill_wen", 64'(mem_wen), 64'(1));
      check("arb_fill_addr", 64'(mem_waddr), 64'(9));
      check("arb_lkp_blocked", 64'(lkp_ready), 64'(0));
      @(posedge clk); #1;
      fill_valid = 1'b0;
      @(negedge clk);
      check("arb_ack_once", 64'(inv_ack), 64'(0));
      check("arb_lkp_rdy2", 64'(lkp_ready), 64'(1));
      check("arb_lkp_ren", 64'(mem_ren), 64'(1));
      @(posedge clk); #1;
      lkp_valid = 1'b0;
      @(negedge clk); @(negedge clk);
      count_expect(1'b0);
      check("arb_rsp_valid", 64'(rsp_valid), 64'(1));
      check("arb_rsp_after_inv", 64'(rsp_hit), 64'(0));
      check("arb_miss_cnt", 64'(miss_cnt), 64'(exp_miss));
      rsp_ready = 1'b1;
      @(posedge clk); #1;
      rsp_ready = 1'b0;

      // Response stall with a fill waiting behind it.
      do_lookup(5'd9, 32'h99, 1'b0, h, t, lat);
      count_expect(1'b1);
      check("stall_hit", 64'(h), 64'(1));
      check("stall_tag", 64'(t), 64'(32'h99));
      held_hit = h; held_tag = t;
      fill_valid = 1'b1; fill_idx = 5'd10; fill_tag = 32'hAA;
      lkp_valid = 1'b1;  lkp_idx = 5'd9;   lkp_tag = 32'h99;
      for (int c = 0; c < 4; c++) begin
         @(negedge clk);
         check("stall_valid", 64'(rsp_valid), 64'(1));
         check("stall_hold_hit", 64'(rsp_hit), 64'(held_hit));
         check("stall_hold_tag", 64'(rsp_tag), 64'(held_tag));
         check("stall_no_fill", 64'(fill_ready | mem_wen), 64'(0));
         check("stall_no_lkp", 64'(lkp_ready | mem_ren), 64'(0));
      end
      rsp_ready = 1'b1;
      @(posedge clk); #1;
      rsp_ready = 1'b0;
      lkp_valid = 1'b0;
      @(negedge clk);
      check("stall_released", 64'(rsp_valid), 64'(0));
      check("stall_fill_wen", 64'(mem_wen), 64'(1));
      check("stall_fill_addr", 64'(mem_waddr), 64'(10));
      @(posedge clk); #1;
      fill_valid = 1'b0;
      do_lookup(5'd10, 32'hAA, 1'b1, h, t, lat);
      count_expect(1'b1);
      check("stall_fill_hit", 64'(h), 64'(1));
      check("stall_hit_cnt", 64'(hit_cnt), 64'(exp_hits));

      // Reset while the controller sits in RD.
      @(posedge clk); #1;
      lkp_valid = 1'b1; lkp_idx = 5'd10; lkp_tag = 32'hAA;
      @(posedge clk); #1;
      lkp_valid = 1'b0;
      #2 rst = 1'b1;
      #1;
      check("rd_rst_valid", 64'(rsp_valid), 64'(0));
      check("rd_rst_hit", 64'(rsp_hit), 64'(0));
      check("rd_rst_tag", 64'(rsp_tag), 64'(0));
      check("rd_rst_hit_cnt", 64'(hit_cnt), 64'(0));
      check("rd_rst_miss_cnt", 64'(miss_cnt), 64'(0));
      check("rd_rst_ack", 64'(inv_ack), 64'(0));
      exp_hits = 0; exp_miss = 0;
      @(negedge clk);
      rst = 1'b0;
      rsp_ready = 1'b1;
      for (int c = 0; c < 5; c++) begin
         @(negedge clk);
         check("rd_rst_no_rsp", 64'(rsp_valid), 64'(0));
      end
      rsp_ready = 1'b0;
      check("rd_rst_cnt_hold", 64'({hit_cnt, miss_cnt}), 64'(0));

      // Miss counter saturation.
      for (int i = 0; i < (1 << CNT_W) + 3; i++) begin
         do_lookup(5'd20, 32'h5, 1'b1, h, t, lat);
         count_expect(1'b0);
         check("sat_miss", 64'(h), 64'(0));
      end
      check("sat_miss_cnt", 64'(miss_cnt), 64'(CNT_MAX));
      check("sat_hit_cnt", 64'(hit_cnt), 64'(0));

      $display("%0d/%0d checks passed", n_pass, n_total);
      $finish;
   end

endmodule

// File: doc/tag_lookup_ctrl.md
Name: tag_lookup_ctrl

Overview:
Controller and arbiter for one single-cycle-invalidate tag/TLB memory (DEPTH entries, WIDTH-bit tag, per-entry valid bit, 1-cycle registered read).
- Shares the memory between three requesters: invalidate-all, fill (write), and lookup (read plus tag compare).
- Sequences each lookup through read, compare and response.
- Keeps saturating hit/miss statistics.
- Sits between the cache/MMU control FSM and the memory instance. The memory's refresh input is tied low at integration.

Parameters:
DEPTH, 32, number of entries; power of two, at least 2.
WIDTH, 32, tag width excluding the valid bit.
CNT_W, 16, width of the hit/miss statistics counters.

Ports:
i_clk  in  1  clock.
i_reset  in  1  asynchronous, active-high reset.
i_inv_req  in  1  request to invalidate all entries.
o_inv_ack  out  1  invalidate accepted; 1-cycle pulse.
i_fill_valid  in  1  fill request.
o_fill_ready  out  1  fill accepted when valid and ready are both high.
i_fill_idx  in  $clog2(DEPTH)  fill index.
i_fill_tag  in  WIDTH  fill tag.
i_lkp_valid  in  1  lookup request.
o_lkp_ready  out  1  lookup accepted when valid and ready are both high.
i_lkp_idx  in  $clog2(DEPTH)  lookup index.
i_lkp_tag  in  WIDTH  tag to compare.
o_rsp_valid  out  1  lookup response valid.
i_rsp_ready  in  1  response consumed.
o_rsp_hit  out  1  valid and tag match.
o_rsp_tag  out  WIDTH  stored tag read from the memory.
o_mem_wen  out  1  memory write enable.
o_mem_waddr  out  $clog2(DEPTH)  memory write address.
o_mem_wdata  out  WIDTH  memory write data.
o_mem_ren  out  1  memory read enable.
o_mem_raddr  out  $clog2(DEPTH)  memory read address.
o_mem_inv  out  1  memory invalidate-all.
i_mem_rdata  in  WIDTH  memory read data; valid 1 cycle after o_mem_ren.
i_mem_rdav  in  1  memory valid bit; valid 1 cycle after o_mem_ren.
o_hit_cnt  out  CNT_W  saturating hit count.
o_miss_cnt  out  CNT_W  saturating miss count.

Behaviour:
- States: IDLE, RD, RSP.
- Reset (asynchronous, any state):
  - State returns to IDLE.
  - Every registered output is 0: o_inv_ack, o_rsp_valid, o_rsp_hit, o_rsp_tag, o_hit_cnt, o_miss_cnt.
  - An in-flight lookup is dropped; no response is ever produced for it.
- Memory-side outputs are combinational from state and requests. They are 0 outside the cases listed below.
- Arbitration in IDLE, fixed priority: invalidate > fill > lookup.
  - o_fill_ready = IDLE & ~i_inv_req.
  - o_lkp_ready = IDLE & ~i_inv_req & ~i_fill_valid.
- Invalidate (IDLE & i_inv_req):
  - o_mem_inv = 1 for that cycle.
  - o_inv_ack = 1 in the next cycle.
  - State stays IDLE.
  - A request held for N cycles is served N times. Each service costs 1 cycle.
- Fill accepted:
  - o_mem_wen = 1, o_mem_waddr = i_fill_idx, o_mem_wdata = i_fill_tag, all in the same cycle.
  - State stays IDLE, so back-to-back fills run at 1 per cycle.
- Lookup accepted in cycle T:
  - o_mem_ren = 1 and o_mem_raddr = i_lkp_idx in cycle T; i_lkp_tag is registered.
  - State goes to RD.
- RD (cycle T+1):
  - hit = i_mem_rdav & (i_mem_rdata == registered tag).
  - o_rsp_hit <= hit; o_rsp_tag <= i_mem_rdata; o_rsp_valid <= 1.
  - Exactly one of the counters increments; it holds at all-ones and never wraps.
  - State goes to RSP.
- RSP:
  - o_rsp_valid, o_rsp_hit and o_rsp_tag stay stable until i_rsp_ready is high.
  - On that cycle o_rsp_valid is cleared and state goes to IDLE.
  - Lookup-to-lookup throughput is therefore at best 1 per 3 cycles. Minimum latency from accept to response is 2 cycles.
- No request is accepted in RD or RSP. This guarantees a read never overlaps a write or invalidate, so no read/write or read/invalidate hazards arise.
- A fill or invalidate that arrives during RD or RSP waits and wins arbitration at the next IDLE cycle.
- Right after reset or an invalidate, every lookup misses because the memory valid bits are 0.
- Requests must stay stable while valid and not ready. This is a requester obligation; the block does not check it.

Decomposition:
- Shared package holds:
  - the state encoding constants (IDLE = 2'd0, RD = 2'd1, RSP = 2'd2);
  - the saturating-increment function used by both counters.
- No sub-module: the controller is a single FSM.
- The memory instance lives in the parent; the controller only drives its ports.

Test Plan:
- Reset, then lookup idx 5 tag 0xABCD -> o_rsp_valid exactly 2 cycles after accept; hit = 0; o_miss_cnt = 1; o_mem_ren high in the accept cycle only.
- Fill idx 5 tag 0xABCD, then lookup idx 5 tag 0xABCD -> hit = 1, o_rsp_tag = 0xABCD, o_hit_cnt = 1. Repeat with tag 0xABCE -> hit = 0, o_rsp_tag = 0xABCD.
- Assert invalidate, fill and lookup in the same IDLE cycle -> o_mem_inv = 1 with fill and lookup not ready. Next cycle the fill is written. Cycle after that the lookup is accepted. o_inv_ack pulses once.
- Hold i_rsp_ready low 4 cycles while valid -> response held stable and no new lookup accepted; a fill presented during the stall is accepted in the first IDLE cycle.
- Assert reset while in RD -> all outputs 0 immediately; no response is produced after reset is released.
- Run (1<<CNT_W)+3 misses with CNT_W = 4 -> o_miss_cnt saturates at 15; o_hit_cnt stays 0.
